// File: rtl/pixel_tone_filter_if.sv
// Pixel stream and configuration bundle between reader, tone filter and writer.
interface pixel_tone_filter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8,
  parameter int unsigned XW = 12
);
  logic [XW-1:0] POSX;
  logic [XW-1:0] POSY;
  logic          READY;
  logic          RDEN;
  logic [DW-1:0] IN_R;
  logic [DW-1:0] IN_G;
  logic [DW-1:0] IN_B;
  logic [1:0]    MODE;
  logic [CW-1:0] COEF_R;
  logic [CW-1:0] COEF_G;
  logic [CW-1:0] COEF_B;
  logic [DW-1:0] THRESH;
  logic          WREN;
  logic [DW-1:0] OUT_R;
  logic [DW-1:0] OUT_G;
  logic [DW-1:0] OUT_B;
  logic [XW-1:0] OUT_POSX;
  logic [XW-1:0] OUT_POSY;
  logic [15:0]   FRAME_CNT;

  modport slave (
    input  POSX, POSY, READY, IN_R, IN_G, IN_B, MODE, COEF_R, COEF_G, COEF_B, THRESH,
    output RDEN, WREN, OUT_R, OUT_G, OUT_B, OUT_POSX, OUT_POSY, FRAME_CNT
  );

  modport master (
    output POSX, POSY, READY, IN_R, IN_G, IN_B, MODE, COEF_R, COEF_G, COEF_B, THRESH,
    input  RDEN, WREN, OUT_R, OUT_G, OUT_B, OUT_POSX, OUT_POSY, FRAME_CNT
  );
endinterface

// File: rtl/pixel_tone_filter.sv
// Per-pixel tone filter: passthrough / weighted gray / binarise / invert, with
// configuration latched at frame start and a fixed latency of PIPE cycles.
module pixel_tone_filter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned XW   = 12,
  parameter int unsigned PIPE = 2
) (
  input logic               CLK,
  input logic               RST,
  pixel_tone_filter_if.slave bus
);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned SW   = DW + CW + 2;
  localparam int unsigned NOUT = PIPE - 1;
  localparam logic [DW-1:0] PixMax = '1;

  typedef struct packed {
    logic [1:0]    mode;
    logic [CW-1:0] coef_r;
    logic [CW-1:0] coef_g;
    logic [CW-1:0] coef_b;
    logic [DW-1:0] thresh;
  } cfg_t;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] prod_r;
    logic [PW-1:0] prod_g;
    logic [PW-1:0] prod_b;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [1:0]    mode;
    logic [DW-1:0] thresh;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
  } out_t;

  localparam cfg_t CfgDefault = '{
    mode:   2'd0,
    coef_r: CW'(77),
    coef_g: CW'(150),
    coef_b: CW'(28),
    thresh: DW'(1 << (DW - 1))
  };

  logic          frame_start;
  cfg_t          live_cfg;
  cfg_t          shadow_d, shadow_q;
  logic [15:0]   frame_cnt_d, frame_cnt_q;
  s1_t           s1_d, s1_q;
  out_t          out_d [NOUT];
  out_t          out_q [NOUT];
  logic [SW-1:0] sum;
  logic [SW-1:0] rounded;
  logic [SW-1:0] gray_full;
  logic [DW-1:0] gray;

  assign bus.RDEN = bus.READY;
  assign frame_start = bus.READY && (bus.POSX == '0) && (bus.POSY == '0);
  assign live_cfg = '{
    mode:   bus.MODE,
    coef_r: bus.COEF_R,
    coef_g: bus.COEF_G,
    coef_b: bus.COEF_B,
    thresh: bus.THRESH
  };

  // Shadow capture, frame counter and stage 1 (products + effective config).
  always_comb begin
    shadow_d    = frame_start ? live_cfg : shadow_q;
    frame_cnt_d = frame_cnt_q + {15'd0, frame_start};
    s1_d        = '0;
    s1_d.vld    = bus.READY;
    // shadow_d already equals the live inputs on a frame-start cycle.
    s1_d.prod_r = PW'(bus.IN_R) * PW'(shadow_d.coef_r);
    s1_d.prod_g = PW'(bus.IN_G) * PW'(shadow_d.coef_g);
    s1_d.prod_b = PW'(bus.IN_B) * PW'(shadow_d.coef_b);
    s1_d.r      = bus.IN_R;
    s1_d.g      = bus.IN_G;
    s1_d.b      = bus.IN_B;
    s1_d.x      = bus.POSX;
    s1_d.y      = bus.POSY;
    s1_d.mode   = shadow_d.mode;
    s1_d.thresh = shadow_d.thresh;
  end

  // Stage 2: round, saturate, apply mode; then pure delay stages.
  always_comb begin
    sum       = SW'(s1_q.prod_r) + SW'(s1_q.prod_g) + SW'(s1_q.prod_b);
    rounded   = sum + SW'(1 << (CW - 1));
    gray_full = rounded >> CW;
    gray      = (gray_full > SW'(PixMax)) ? PixMax : gray_full[DW-1:0];
    for (int i = 0; i < NOUT; i++) out_d[i] = '0;
    out_d[0].vld = s1_q.vld;
    out_d[0].x   = s1_q.x;
    out_d[0].y   = s1_q.y;
    case (s1_q.mode)
      2'd0: begin
        out_d[0].r = s1_q.r;
        out_d[0].g = s1_q.g;
        out_d[0].b = s1_q.b;
      end
      2'd1: begin
        out_d[0].r = gray;
        out_d[0].g = gray;
        out_d[0].b = gray;
      end
      2'd2: begin
        out_d[0].r = (gray >= s1_q.thresh) ? PixMax : '0;
        out_d[0].g = (gray >= s1_q.thresh) ? PixMax : '0;
        out_d[0].b = (gray >= s1_q.thresh) ? PixMax : '0;
      end
      default: begin
        out_d[0].r = PixMax - s1_q.r;
        out_d[0].g = PixMax - s1_q.g;
        out_d[0].b = PixMax - s1_q.b;
      end
    endcase
    for (int i = 1; i < NOUT; i++) out_d[i] = out_q[i-1];
  end

  // All state, cleared asynchronously so in-flight pixels vanish on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shadow_q    <= CfgDefault;
      frame_cnt_q <= '0;
      s1_q        <= '0;
      for (int i = 0; i < NOUT; i++) out_q[i] <= '0;
    end else begin
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      s1_q        <= s1_d;
      for (int i = 0; i < NOUT; i++) out_q[i] <= out_d[i];
    end
  end

  assign bus.WREN      = out_q[NOUT-1].vld;
  assign bus.OUT_R     = out_q[NOUT-1].r;
  assign bus.OUT_G     = out_q[NOUT-1].g;
  assign bus.OUT_B     = out_q[NOUT-1].b;
  assign bus.OUT_POSX  = out_q[NOUT-1].x;
  assign bus.OUT_POSY  = out_q[NOUT-1].y;
  assign bus.FRAME_CNT = frame_cnt_q;
endmodule

// File: tb/tb_pixel_tone_filter.sv
// Bench for pixel_tone_filter: two instances (PIPE=2 and PIPE=4) share one
// stimulus stream and are compared against a behavioural pixel model.
module tb_pixel_tone_filter;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int XW = 12;
  localparam int PMAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [XW-1:0] posx, posy;
  logic          ready;
  logic [DW-1:0] in_r, in_g, in_b, thresh;
  logic [1:0]    mode;
  logic [CW-1:0] cr, cg, cb;

  pixel_tone_filter_if #(.DW(DW), .CW(CW), .XW(XW)) bus2 ();
  pixel_tone_filter_if #(.DW(DW), .CW(CW), .XW(XW)) bus4 ();

  assign bus2.POSX = posx;   assign bus4.POSX = posx;
  assign bus2.POSY = posy;   assign bus4.POSY = posy;
  assign bus2.READY = ready; assign bus4.READY = ready;
  assign bus2.IN_R = in_r;   assign bus4.IN_R = in_r;
  assign bus2.IN_G = in_g;   assign bus4.IN_G = in_g;
  assign bus2.IN_B = in_b;   assign bus4.IN_B = in_b;
  assign bus2.MODE = mode;   assign bus4.MODE = mode;
  assign bus2.COEF_R = cr;   assign bus4.COEF_R = cr;
  assign bus2.COEF_G = cg;   assign bus4.COEF_G = cg;
  assign bus2.COEF_B = cb;   assign bus4.COEF_B = cb;
  assign bus2.THRESH = thresh; assign bus4.THRESH = thresh;

  pixel_tone_filter #(.DW(DW), .CW(CW), .XW(XW), .PIPE(2)) u_dut2 (
    .CLK(clk), .RST(rst_n), .bus(bus2)
  );
  pixel_tone_filter #(.DW(DW), .CW(CW), .XW(XW), .PIPE(4)) u_dut4 (
    .CLK(clk), .RST(rst_n), .bus(bus4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model configuration as seen by the next accepted pixel.
  int m_mode, m_cr, m_cg, m_cb, m_th, m_fc;

  // Expected output per driven cycle, indexed by cycle modulo 16.
  bit h_vld [16];
  int h_r [16], h_g [16], h_b [16], h_x [16], h_y [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_px(input int md, input int c_r, input int c_g, input int c_b,
                                 input int th, input int r, input int g, input int b,
                                 output int o_r, output int o_g, output int o_b);
    int s, gy;
    s  = r * c_r + g * c_g + b * c_b;
    gy = (s + (1 << (CW - 1))) >> CW;
    if (gy > PMAX) gy = PMAX;
    case (md)
      0: begin o_r = r; o_g = g; o_b = b; end
      1: begin o_r = gy; o_g = gy; o_b = gy; end
      2: begin o_r = (gy >= th) ? PMAX : 0; o_g = o_r; o_b = o_r; end
      default: begin o_r = PMAX - r; o_g = PMAX - g; o_b = PMAX - b; end
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cr = 77; m_cg = 150; m_cb = 28; m_th = 1 << (DW - 1); m_fc = 0;
    for (int i = 0; i < 16; i++) h_vld[i] = 1'b0;
  endtask

  task automatic check_out(input string nm, input int p, input logic wr,
                           input logic [DW-1:0] r, input logic [DW-1:0] g,
                           input logic [DW-1:0] b, input logic [XW-1:0] x,
                           input logic [XW-1:0] y);
    int k;
    bit ev;
    k  = cyc - p;
    ev = (k >= 0) ? h_vld[k % 16] : 1'b0;
    chk({nm, ".wren"}, wr, ev);
    if (ev) begin
      chk({nm, ".out_r"}, r, h_r[k % 16]);
      chk({nm, ".out_g"}, g, h_g[k % 16]);
      chk({nm, ".out_b"}, b, h_b[k % 16]);
      chk({nm, ".posx"}, x, h_x[k % 16]);
      chk({nm, ".posy"}, y, h_y[k % 16]);
    end
  endtask

  // One clock: check outputs on the falling edge, then drive the next inputs.
  task automatic step(input bit rdy, input int x, input int y, input int r, input int g,
                      input int b, input int md, input int c_r, input int c_g,
                      input int c_b, input int th);
    int er, eg, eb;
    @(negedge clk);
    check_out("p2", 2, bus2.WREN, bus2.OUT_R, bus2.OUT_G, bus2.OUT_B,
              bus2.OUT_POSX, bus2.OUT_POSY);
    check_out("p4", 4, bus4.WREN, bus4.OUT_R, bus4.OUT_G, bus4.OUT_B,
              bus4.OUT_POSX, bus4.OUT_POSY);
    chk("p2.frame_cnt", bus2.FRAME_CNT, m_fc & 16'hffff);
    chk("p4.frame_cnt", bus4.FRAME_CNT, m_fc & 16'hffff);
    ready = rdy; posx = XW'(x); posy = XW'(y);
    in_r = DW'(r); in_g = DW'(g); in_b = DW'(b);
    mode = 2'(md); cr = CW'(c_r); cg = CW'(c_g); cb = CW'(c_b); thresh = DW'(th);
    if (rdy && x == 0 && y == 0) begin
      m_mode = md; m_cr = c_r; m_cg = c_g; m_cb = c_b; m_th = th; m_fc++;
    end
    ref_px(m_mode, m_cr, m_cg, m_cb, m_th, r, g, b, er, eg, eb);
    h_vld[cyc % 16] = rdy;
    h_r[cyc % 16] = er; h_g[cyc % 16] = eg; h_b[cyc % 16] = eb;
    h_x[cyc % 16] = x;  h_y[cyc % 16] = y;
    cyc++;
    #1;
    chk("p2.rden", bus2.RDEN, rdy);
    chk("p4.rden", bus4.RDEN, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int x, y, acc, iter, md, c_r, c_g, c_b, th;
    bit rdy;
    ready = 1'b0; posx = '0; posy = '0; in_r = '0; in_g = '0; in_b = '0;
    mode = '0; cr = '0; cg = '0; cb = '0; thresh = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.wren2", bus2.WREN, 0);
    chk("reset.wren4", bus4.WREN, 0);
    chk("reset.out2", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, 0);
    chk("reset.fcnt", bus2.FRAME_CNT, 0);
    rst_n = 1'b1;

    // Default shadow mode is passthrough even with MODE=1 live off-frame
    step(1'b1, 3, 0, 40, 80, 120, 1, 10, 10, 10, 0);
    idle(2);
    chk("dflt.wren", bus2.WREN, 1);
    chk("dflt.out", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, {8'd40, 8'd80, 8'd120});
    idle(2);

    // Gray with rounding, both latencies
    step(1'b1, 0, 0, 100, 150, 200, 1, 77, 150, 28, 128);
    idle(2);
    chk("gray.p2", {bus2.WREN, bus2.OUT_R, bus2.OUT_G, bus2.OUT_B},
        {1'b1, 8'd140, 8'd140, 8'd140});
    idle(2);
    chk("gray.p4", {bus4.WREN, bus4.OUT_R, bus4.OUT_G, bus4.OUT_B},
        {1'b1, 8'd140, 8'd140, 8'd140});

    // Saturation followed by back-to-back frame start into binarise
    step(1'b1, 0, 0, 255, 255, 255, 1, 255, 255, 255, 128);
    step(1'b1, 0, 0, 100, 150, 200, 2, 77, 150, 28, 128);
    step(1'b1, 1, 0, 20, 20, 20, 0, 1, 1, 1, 0);
    chk("sat.out", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, {8'd255, 8'd255, 8'd255});
    idle(1);
    chk("bin.hi", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, {8'd255, 8'd255, 8'd255});
    idle(1);
    chk("bin.lo", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, 0);
    idle(2);

    // Config change mid-frame takes effect only at the next frame start
    step(1'b1, 0, 0, 10, 20, 30, 3, 77, 150, 28, 128);
    step(1'b1, 5, 0, 10, 20, 30, 1, 77, 150, 28, 128);
    idle(2);
    chk("inv.hold", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, {8'd245, 8'd235, 8'd225});
    step(1'b1, 0, 0, 100, 150, 200, 1, 77, 150, 28, 128);
    idle(2);
    chk("inv.next", {bus2.OUT_R, bus2.OUT_G, bus2.OUT_B}, {8'd140, 8'd140, 8'd140});
    idle(2);

    // Random streaming with gaps and random live config changes
    x = 0; y = 0; acc = 0; iter = 0;
    md = 1; c_r = 77; c_g = 150; c_b = 28; th = 128;
    while (acc < 1000 && iter < 5000) begin
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        md = $urandom_range(0, 3);
        c_r = $urandom_range(0, 255); c_g = $urandom_range(0, 255);
        c_b = $urandom_range(0, 255); th = $urandom_range(0, 255);
      end
      step(rdy, x, y, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), md, c_r, c_g, c_b, th);
      iter++;
      if (rdy) begin
        acc++;
        x++;
        if (x == 24) begin
          x = 0;
          y = (y == 5) ? 0 : y + 1;
        end
      end
    end
    chk("stream.budget", acc, 1000);
    idle(4);

    // Asynchronous reset with pixels in flight
    step(1'b1, 1, 1, 11, 22, 33, 0, 0, 0, 0, 0);
    step(1'b1, 2, 1, 44, 55, 66, 0, 0, 0, 0, 0);
    step(1'b1, 3, 1, 77, 88, 99, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    chk("arst.wren2", bus2.WREN, 0);
    chk("arst.wren4", bus4.WREN, 0);
    chk("arst.fcnt", bus2.FRAME_CNT, 0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(6);
    step(1'b1, 4, 2, 1, 2, 3, 3, 0, 0, 0, 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
